dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port memwrite, input, 1 bit: store strobe from the MEM stage.
REQ-004 SHALL have port addr, input, 32 bits: byte address (aluout of the MEM stage); addr[1:0] ignored.
REQ-005 SHALL have port wdata, input, 32 bits: store data.
REQ-006 SHALL have port rdata, output, 32 bits: load data, combinational from addr.
REQ-007 SHALL have port console_data, output, 8 bits: head byte of the console FIFO.
REQ-008 SHALL have port console_valid, output, 1 bit: asserted whenever the FIFO is not empty.
REQ-009 SHALL have port console_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 SHALL have port timer_irq, output, 1 bit: the timer pending flag.

Function
REQ-011 Memory map SHALL be:
- RAM at 0x0000_0000-0x0000_00FC: 64 x 32, indexed by addr[7:2].
- 0x0000_FF00 CYCLE: read-only.
- 0x0000_FF04 TCMP: read/write.
- 0x0000_FF08 STATUS.
- 0x0000_FF0C CONSOLE: write-only.
REQ-012 Reads of any unmapped address, and of CONSOLE, SHALL return 0; writes to unmapped addresses, and to CYCLE, SHALL be ignored.
REQ-013 A RAM write SHALL occur at the rising edge when memwrite=1; a read of the same address in the following cycle SHALL return the new data.
REQ-014 A same-cycle read of an address being written SHALL return the old data.
REQ-015 CYCLE SHALL increment by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
REQ-016 timer_irq SHALL be set on the edge at which CYCLE==TCMP.
REQ-017 Writing STATUS with wdata[0]=1 SHALL clear timer_irq; if set and clear coincide in the same cycle, set SHALL win.
REQ-018 STATUS read SHALL return bit0 timer_irq, bit1 full, bit2 empty, bit3 overflow, bits6:4 count (0-4), and all other bits 0.
REQ-019 Console FIFO SHALL be 4 entries x 8 bits, circular, with 2-bit read/write pointers and a 3-bit count.
REQ-020 A write to CONSOLE SHALL push wdata[7:0].
REQ-021 A pop SHALL occur when console_valid && console_ready.
REQ-022 Push while full with no pop in the same cycle SHALL drop the byte and set overflow (sticky).
REQ-023 Push while full with a pop in the same cycle SHALL accept the byte; count stays 4.
REQ-024 Push while empty SHALL accept the byte; no pop occurs that cycle, since console_valid=0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged.
REQ-026 Writing STATUS with wdata[3]=1 SHALL clear overflow; a same-cycle new overflow SHALL win.
REQ-027 Pointers SHALL wrap modulo 4; console_data SHALL be driven from the read pointer even when empty (value don't-care).

Reset
REQ-028 On reset the block SHALL set CYCLE=0, TCMP=0xFFFFFFFF, timer_irq=0, overflow=0, FIFO empty (pointers=0, count=0), and console_valid=0.
REQ-029 RAM contents SHALL be unaffected by reset.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents and any pending write in that cycle; reset SHALL take priority over all other updates.
REQ-031 In the first cycle after reset deasserts, a CYCLE read SHALL return 0.

Verification
REQ-032 RAM: write 0xDEADBEEF to 0x10 -> next cycle rdata=0xDEADBEEF at 0x10 and at 0x13; a read of 0x100 returns 0.
REQ-033 Timer: after reset write TCMP=20 -> timer_irq rises at the edge where CYCLE==20; a STATUS write of 0x1 clears it; a clear written on the set edge leaves it at 1.
REQ-034 FIFO fill: console_ready=0, push 0x41..0x45 -> STATUS=0x4A (count 4, full, overflow), console_data=0x41; the 0x45 byte is lost.
REQ-035 Drain: console_ready=1 -> bytes 0x41,0x42,0x43,0x44 on consecutive cycles, then console_valid=0 and STATUS bit2=1; pushing while full with ready=1 leaves count at 4 and sets no overflow.
REQ-036 Reset mid-drain with 2 bytes queued -> console_valid=0 on the next cycle, count=0, CYCLE=0, and RAM data intact.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped cycle counter, compare timer and a 4-deep console FIFO.
// All state updates on the rising edge of clk; reset is synchronous and active-high.
module dmem_mmio (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        timer_irq
);

  localparam logic [31:0] ADDR_CYCLE   = 32'h0000_FF00;
  localparam logic [31:0] ADDR_TCMP    = 32'h0000_FF04;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_FF08;
  localparam logic [31:0] ADDR_CONSOLE = 32'h0000_FF0C;

  logic [31:0] ram_q [64];
  logic [7:0]  fifo_q [4];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;

  logic sel_ram, sel_cycle, sel_tcmp, sel_status, sel_console;
  logic ram_we, tcmp_we, status_we, push;
  logic full, empty, pop, accept, drop;
  logic [31:0] status_word;
  logic unused_addr_bits;

  // Word-granular decode; the byte offset never takes part.
  assign sel_ram     = (addr[31:8] == 24'h0);
  assign sel_cycle   = (addr[31:2] == ADDR_CYCLE[31:2]);
  assign sel_tcmp    = (addr[31:2] == ADDR_TCMP[31:2]);
  assign sel_status  = (addr[31:2] == ADDR_STATUS[31:2]);
  assign sel_console = (addr[31:2] == ADDR_CONSOLE[31:2]);
  assign unused_addr_bits = ^addr[1:0];

  assign ram_we    = memwrite && sel_ram     && !reset;
  assign tcmp_we   = memwrite && sel_tcmp    && !reset;
  assign status_we = memwrite && sel_status  && !reset;
  assign push      = memwrite && sel_console && !reset;

  assign full   = (count_q == 3'd4);
  assign empty  = (count_q == 3'd0);
  assign pop    = console_valid && console_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign console_valid = !empty;
  assign console_data  = fifo_q[rd_ptr_q];
  assign timer_irq     = irq_q;
  assign status_word   = {25'd0, count_q, ovf_q, empty, full, irq_q};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    if (sel_ram)         rdata = ram_q[addr[7:2]];
    else if (sel_cycle)  rdata = cycle_q;
    else if (sel_tcmp)   rdata = tcmp_q;
    else if (sel_status) rdata = status_word;
  end

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    tcmp_d   = tcmp_we ? wdata : tcmp_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q + 2'(pop);
    wr_ptr_d = wr_ptr_q + 2'(accept);
    count_d  = count_q + 3'(accept) - 3'(pop);
    // Clears are applied first so a coincident set overrides them.
    if (status_we && wdata[0]) irq_d = 1'b0;
    if (cycle_q == tcmp_q)     irq_d = 1'b1;
    if (status_we && wdata[3]) ovf_d = 1'b0;
    if (drop)                  ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      tcmp_q   <= '1;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cycle_q  <= cycle_d;
      tcmp_q   <= tcmp_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays have no reset; the write enables are already blocked while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[addr[7:2]] <= wdata;
    if (accept) fifo_q[wr_ptr_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: expectations are queued as stimulus is applied and popped as outputs are sampled.
module tb_dmem_mmio;

  localparam logic [31:0] A_CYCLE   = 32'h0000_FF00;
  localparam logic [31:0] A_TCMP    = 32'h0000_FF04;
  localparam logic [31:0] A_STATUS  = 32'h0000_FF08;
  localparam logic [31:0] A_CONSOLE = 32'h0000_FF0C;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic        timer_irq;

  int unsigned n_cmp;
  int unsigned n_fail;
  int unsigned exp_cycle;
  string       tag_q[$];
  logic [31:0] val_q[$];

  dmem_mmio dut (
    .clk           (clk),
    .reset         (reset),
    .memwrite      (memwrite),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .console_data  (console_data),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .timer_irq     (timer_irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_cycle++;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] val;
    n_cmp++;
    if (val_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %h, expected a queued value", obs);
    end else begin
      tag = tag_q.pop_front();
      val = val_q.pop_front();
      assert (obs === val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, val);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    memwrite = 1'b0;
    addr     = '0;
    wdata    = '0;
  endtask

  task automatic probe(input logic [31:0] a, input string tag, input logic [31:0] val);
    addr = a;
    expect_val(tag, val);
    #1;
    check(rdata);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_cycle = 0;
    reset = 1'b1; memwrite = 1'b0; addr = '0; wdata = '0; console_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_cycle = 0;

    // Reset state, sampled in the first cycle after reset deasserts.
    probe(A_CYCLE,  "rst_cycle",  32'd0);
    probe(A_TCMP,   "rst_tcmp",   32'hFFFF_FFFF);
    probe(A_STATUS, "rst_status", 32'h0000_0004);
    expect_val("rst_valid", 32'd0); check(32'(console_valid));
    expect_val("rst_irq",   32'd0); check(32'(timer_irq));

    // Timer: compare at 20, clear, then clear coinciding with a set.
    wr(A_TCMP, 32'd20);
    probe(A_TCMP, "tcmp_rd", 32'd20);
    repeat (18) tick();
    probe(A_CYCLE, "cycle_count", 32'(exp_cycle));
    tick();
    expect_val("irq_pre_match", 32'd0); check(32'(timer_irq));
    tick();
    expect_val("irq_set", 32'd1); check(32'(timer_irq));
    probe(A_STATUS, "status_irq", 32'h0000_0005);
    wr(A_STATUS, 32'h1);
    expect_val("irq_clear", 32'd0); check(32'(timer_irq));
    wr(A_TCMP, 32'(exp_cycle + 2));
    tick();
    wr(A_STATUS, 32'h1);
    expect_val("irq_set_wins", 32'd1); check(32'(timer_irq));
    wr(A_STATUS, 32'h1);
    expect_val("irq_clear2", 32'd0); check(32'(timer_irq));

    // RAM access, byte-offset aliasing, unmapped reads and writes.
    wr(32'h10, 32'hDEAD_BEEF);
    probe(32'h10,  "ram_rd",      32'hDEAD_BEEF);
    probe(32'h13,  "ram_rd_off3", 32'hDEAD_BEEF);
    probe(32'h100, "unmapped_rd", 32'd0);
    memwrite = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
    expect_val("ram_same_cycle_old", 32'hDEAD_BEEF);
    #1; check(rdata);
    tick();
    memwrite = 1'b0;
    probe(32'h10, "ram_new", 32'h1234_5678);
    wr(32'h0,   32'hAAAA_5555);
    wr(32'h200, 32'h0BAD_0BAD);
    probe(32'h0,   "ram_no_alias", 32'hAAAA_5555);
    probe(32'h200, "unmapped_wr",  32'd0);
    wr(A_CYCLE, 32'd0);
    probe(A_CYCLE,   "cycle_ro",   32'(exp_cycle));
    probe(A_CONSOLE, "console_rd", 32'd0);

    // FIFO fill past capacity with no consumer.
    console_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h45; b++) wr(A_CONSOLE, 32'(b));
    probe(A_STATUS, "fill_status", 32'h0000_004A);
    expect_val("fill_head",  32'h41); check(32'(console_data));
    expect_val("fill_valid", 32'd1);  check(32'(console_valid));
    wr(A_STATUS, 32'h8);
    probe(A_STATUS, "ovf_clear", 32'h0000_0042);

    // Drain: the four accepted bytes appear in order, one per cycle.
    for (int b = 8'h41; b <= 8'h44; b++) expect_val("drain_byte", 32'(b));
    console_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check(32'(console_data));
      tick();
    end
    expect_val("drain_valid", 32'd0); check(32'(console_valid));
    probe(A_STATUS, "drain_status", 32'h0000_0004);

    // Push while full with a same-cycle pop.
    console_ready = 1'b0;
    for (int b = 8'h51; b <= 8'h54; b++) wr(A_CONSOLE, 32'(b));
    probe(A_STATUS, "refill_status", 32'h0000_0042);
    console_ready = 1'b1;
    wr(A_CONSOLE, 32'h55);
    probe(A_STATUS, "push_pop_full", 32'h0000_0042);
    expect_val("push_pop_head", 32'h52); check(32'(console_data));
    tick(); tick();
    probe(A_STATUS, "two_queued", 32'h0000_0020);
    expect_val("two_queued_head", 32'h54); check(32'(console_data));

    // Reset mid-drain with a RAM write pending in the same cycle.
    reset = 1'b1; memwrite = 1'b1; addr = 32'h10; wdata = 32'hFFFF_0000;
    tick();
    reset = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    exp_cycle = 0;
    probe(A_CYCLE, "mid_rst_cycle", 32'd0);
    expect_val("mid_rst_valid", 32'd0); check(32'(console_valid));
    probe(A_STATUS, "mid_rst_status", 32'h0000_0004);
    probe(32'h10, "mid_rst_ram",  32'h1234_5678);
    probe(32'h0,  "mid_rst_ram0", 32'hAAAA_5555);
    probe(A_TCMP, "mid_rst_tcmp", 32'hFFFF_FFFF);
    tick();
    probe(A_CYCLE, "post_rst_cycle", 32'(exp_cycle));

    if (val_q.size() != 0) begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d unchecked entries, expected 0", val_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
